// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-bank target.
package i2c_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdataAck,
    StIgnore
  } i2c_tgt_state_t;

  localparam logic       I2C_ACK   = 1'b0;
  localparam logic       I2C_NACK  = 1'b1;
  localparam logic [3:0] BYTE_BITS = 4'd8;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser plus a glitch filter that accepts a new level only after
// FILTER_LEN consecutive equal samples; emits one-cycle rise/fall pulses with the level change.
module i2c_line_filter #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CntW = $clog2(FILTER_LEN + 1);

  logic            sync1_q, sync2_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      level   <= 1'b1;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      sync1_q <= line_in;
      sync2_q <= sync1_q;
      rise    <= 1'b0;
      fall    <= 1'b0;
      if (sync2_q == level) begin
        cnt_q <= '0;
      end else if (cnt_q == CntW'(FILTER_LEN - 1)) begin
        cnt_q <= '0;
        level <= sync2_q;
        rise  <= sync2_q;
        fall  <= ~sync2_q;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_target_regs.sv
// I2C/SCCB target emulating a camera sensor's 8-bit-addressed register interface.
// Register pointer auto-increments per data byte and persists across transactions.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0]  TARGET_ADDR = 7'h21,
  parameter int unsigned FILTER_LEN  = 3,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk     (clk),
    .reset   (reset),
    .line_in (scl_in),
    .level   (scl_lvl),
    .rise    (scl_rise),
    .fall    (scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk     (clk),
    .reset   (reset),
    .line_in (sda_in),
    .level   (sda_lvl),
    .rise    (sda_rise),
    .fall    (sda_fall)
  );

  i2c_tgt_state_t   state_q;
  logic [3:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic [7:0]       ptr_q;
  logic [HoldW-1:0] hold_cnt_q;
  logic             rw_q;
  logic             rd_pend_q;

  logic [7:0] byte_in;
  logic       last_bit;
  logic       drive_low;

  assign byte_in  = {shift_q[6:0], sda_lvl};
  assign last_bit = (bit_cnt_q == BYTE_BITS - 4'd1);

  // Level SDA should take once the post-fall hold time expires.
  always_comb begin
    drive_low = 1'b0;
    unique case (state_q)
      StAddrAck, StPtrAck, StWdataAck: drive_low = 1'b1;
      StRdata:                         drive_low = ~shift_q[7];
      default:                         drive_low = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      rw_q       <= 1'b0;
      rd_pend_q  <= 1'b0;
      sda_oe     <= 1'b0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      reg_we     <= 1'b0;
      reg_rd     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      reg_we    <= 1'b0;
      reg_rd    <= 1'b0;
      rd_pend_q <= reg_rd;
      // Read data arrives one clk after the request.
      if (rd_pend_q) shift_q <= reg_rdata;

      if (scl_fall) begin
        hold_cnt_q <= HoldW'(HOLD_CYCLES);
      end else if (hold_cnt_q != '0) begin
        hold_cnt_q <= hold_cnt_q - HoldW'(1);
        if (hold_cnt_q == HoldW'(1)) sda_oe <= drive_low;
      end

      if (scl_lvl && (sda_fall || sda_rise)) begin
        state_q    <= sda_fall ? StAddr : StIdle;
        bit_cnt_q  <= '0;
        hold_cnt_q <= '0;
        sda_oe     <= 1'b0;
        busy       <= 1'b0;
      end else if (scl_rise) begin
        unique case (state_q)
          StAddr: begin
            shift_q   <= byte_in;
            bit_cnt_q <= last_bit ? 4'd0 : bit_cnt_q + 4'd1;
            if (last_bit) begin
              if (byte_in[7:1] == TARGET_ADDR) begin
                state_q <= StAddrAck;
                busy    <= 1'b1;
                rw_q    <= byte_in[0];
                if (byte_in[0]) begin
                  reg_rd   <= 1'b1;
                  reg_addr <= ptr_q;
                end
              end else begin
                state_q <= StIgnore;
              end
            end
          end
          StAddrAck: state_q <= rw_q ? StRdata : StPtr;
          StPtr: begin
            shift_q   <= byte_in;
            bit_cnt_q <= last_bit ? 4'd0 : bit_cnt_q + 4'd1;
            if (last_bit) begin
              ptr_q   <= byte_in;
              state_q <= StPtrAck;
            end
          end
          StPtrAck, StWdataAck: state_q <= StWdata;
          StWdata: begin
            shift_q   <= byte_in;
            bit_cnt_q <= last_bit ? 4'd0 : bit_cnt_q + 4'd1;
            if (last_bit) begin
              reg_we    <= 1'b1;
              reg_addr  <= ptr_q;
              reg_wdata <= byte_in;
              ptr_q     <= ptr_q + 8'd1;
              state_q   <= StWdataAck;
            end
          end
          StRdata: begin
            shift_q   <= {shift_q[6:0], 1'b0};
            bit_cnt_q <= last_bit ? 4'd0 : bit_cnt_q + 4'd1;
            if (last_bit) state_q <= StRdataAck;
          end
          StRdataAck: begin
            ptr_q <= ptr_q + 8'd1;
            if (sda_lvl == I2C_ACK) begin
              reg_rd   <= 1'b1;
              reg_addr <= ptr_q + 8'd1;
              state_q  <= StRdata;
            end else begin
              state_q <= StIgnore;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench: bit-banged I2C initiator, register-strobe scoreboard, immediate assertions.
module tb_i2c_target_regs;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_we, reg_rd, busy;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } ev_t;
  ev_t exp_q[$];

  logic oe_seen, busy_seen;

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_regs dut (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl_m),
    .sda_in    (sda_line),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_rd    (reg_rd),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  // Register bank with one clk read latency; contents = addr ^ 8'hFF.
  always @(posedge clk) if (reg_rd) reg_rdata <= reg_addr ^ 8'hFF;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sda_oe) oe_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
    if (!reset && (reg_we || reg_rd)) begin
      ev_t e;
      check8("we_rd_exclusive", {7'd0, reg_we & reg_rd}, 8'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL unexpected_strobe: observed we=%b rd=%b addr=%h expected none",
               reg_we, reg_rd, reg_addr);
      end else begin
        e = exp_q.pop_front();
        check8("strobe_kind", {7'd0, reg_we}, {7'd0, e.we});
        check8("strobe_addr", reg_addr, e.addr);
        if (e.we) check8("strobe_wdata", reg_wdata, e.data);
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clock_bit(input logic b, input logic g_scl, input logic g_sda, output logic s);
    sda_m = b;
    wait_clks(5);
    if (g_scl) begin
      scl_m = 1'b1; wait_clks(1); scl_m = 1'b0; wait_clks(4);
    end else wait_clks(5);
    scl_m = 1'b1;
    wait_clks(10);
    s = sda_line;
    if (g_sda) begin
      sda_m = ~b; wait_clks(1); sda_m = b; wait_clks(9);
    end else wait_clks(10);
    scl_m = 1'b0;
    wait_clks(10);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clks(10);
    scl_m = 1'b1; wait_clks(20);
    sda_m = 1'b0; wait_clks(20);
    scl_m = 1'b0; wait_clks(10);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clks(10);
    scl_m = 1'b1; wait_clks(20);
    sda_m = 1'b1; wait_clks(20);
  endtask

  task automatic write_byte(input logic [7:0] d, input logic [7:0] g_scl,
                            input logic [7:0] g_sda, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], g_scl[i], g_sda[i], s);
    clock_bit(1'b1, 1'b0, 1'b0, ack);
  endtask

  task automatic read_byte(input logic m_ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, 1'b0, 1'b0, s);
      d[i] = s;
    end
    clock_bit(m_ack, 1'b0, 1'b0, s);
  endtask

  function automatic ev_t ev(input logic we, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    e.we = we; e.addr = a; e.data = d;
    return e;
  endfunction

  initial begin
    logic       ack, s;
    logic [7:0] d;
    oe_seen = 1'b0;
    busy_seen = 1'b0;

    wait_clks(4);
    check8("rst_sda_oe", {7'd0, sda_oe}, 8'd0);
    check8("rst_reg_we", {7'd0, reg_we}, 8'd0);
    check8("rst_reg_rd", {7'd0, reg_rd}, 8'd0);
    check8("rst_busy", {7'd0, busy}, 8'd0);
    check8("rst_reg_addr", reg_addr, 8'h00);
    check8("rst_reg_wdata", reg_wdata, 8'h00);
    reset = 1'b0;
    wait_clks(10);

    // Plain write of two bytes.
    exp_q.push_back(ev(1'b1, 8'h12, 8'hA5));
    exp_q.push_back(ev(1'b1, 8'h13, 8'h3C));
    i2c_start();
    write_byte(8'h42, 8'h00, 8'h00, ack); check8("w_addr_ack", {7'd0, ack}, 8'd0);
    check8("w_busy_set", {7'd0, busy}, 8'd1);
    write_byte(8'h12, 8'h00, 8'h00, ack); check8("w_ptr_ack", {7'd0, ack}, 8'd0);
    write_byte(8'hA5, 8'h00, 8'h00, ack); check8("w_d0_ack", {7'd0, ack}, 8'd0);
    write_byte(8'h3C, 8'h00, 8'h00, ack); check8("w_d1_ack", {7'd0, ack}, 8'd0);
    i2c_stop();
    check8("w_busy_clear", {7'd0, busy}, 8'd0);

    // Combined pointer write, repeated START, two-byte read.
    exp_q.push_back(ev(1'b0, 8'h12, 8'h00));
    exp_q.push_back(ev(1'b0, 8'h13, 8'h00));
    i2c_start();
    write_byte(8'h42, 8'h00, 8'h00, ack); check8("r_waddr_ack", {7'd0, ack}, 8'd0);
    write_byte(8'h12, 8'h00, 8'h00, ack); check8("r_ptr_ack", {7'd0, ack}, 8'd0);
    i2c_start();
    write_byte(8'h43, 8'h00, 8'h00, ack); check8("r_raddr_ack", {7'd0, ack}, 8'd0);
    read_byte(1'b0, d); check8("r_byte0", d, 8'hED);
    read_byte(1'b1, d); check8("r_byte1", d, 8'hEC);
    i2c_stop();

    // Foreign address: no drive, no strobes, never busy.
    oe_seen = 1'b0;
    busy_seen = 1'b0;
    i2c_start();
    write_byte(8'h44, 8'h00, 8'h00, ack); check8("x_addr_nack", {7'd0, ack}, 8'd1);
    write_byte(8'h01, 8'h00, 8'h00, ack); check8("x_b0_nack", {7'd0, ack}, 8'd1);
    write_byte(8'h02, 8'h00, 8'h00, ack);
    write_byte(8'h03, 8'h00, 8'h00, ack);
    i2c_stop();
    check8("x_oe_never", {7'd0, oe_seen}, 8'd0);
    check8("x_busy_never", {7'd0, busy_seen}, 8'd0);

    // Pointer wrap.
    exp_q.push_back(ev(1'b1, 8'hFF, 8'h01));
    exp_q.push_back(ev(1'b1, 8'h00, 8'h02));
    i2c_start();
    write_byte(8'h42, 8'h00, 8'h00, ack);
    write_byte(8'hFF, 8'h00, 8'h00, ack);
    write_byte(8'h01, 8'h00, 8'h00, ack); check8("wrap_d0_ack", {7'd0, ack}, 8'd0);
    write_byte(8'h02, 8'h00, 8'h00, ack); check8("wrap_d1_ack", {7'd0, ack}, 8'd0);
    i2c_stop();

    // Short glitches inside a byte, then a STOP that aborts a byte halfway.
    exp_q.push_back(ev(1'b1, 8'h30, 8'h5A));
    i2c_start();
    write_byte(8'h42, 8'h00, 8'h00, ack);
    write_byte(8'h30, 8'h00, 8'h00, ack);
    write_byte(8'h5A, 8'h20, 8'h04, ack); check8("g_data_ack", {7'd0, ack}, 8'd0);
    check8("g_busy_kept", {7'd0, busy}, 8'd1);
    for (int i = 0; i < 4; i++) clock_bit(1'b1, 1'b0, 1'b0, s);
    i2c_stop();
    check8("abort_busy", {7'd0, busy}, 8'd0);
    sda_m = 1'b0; wait_clks(1); sda_m = 1'b1; wait_clks(20);
    check8("idle_glitch_busy", {7'd0, busy}, 8'd0);
    check8("abort_queue", exp_q.size() == 0 ? 8'd0 : 8'd1, 8'd0);

    // Reset while acknowledging the address.
    i2c_start();
    for (int i = 7; i >= 0; i--) clock_bit(((8'h42 >> i) & 8'h01) != 0, 1'b0, 1'b0, s);
    sda_m = 1'b1; wait_clks(10);
    scl_m = 1'b1; wait_clks(5);
    check8("ack_driving", {7'd0, sda_oe}, 8'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check8("rst_release_same_edge", {7'd0, sda_oe}, 8'd0);
    wait_clks(2);
    reset = 1'b0;
    wait_clks(30);
    exp_q.push_back(ev(1'b0, 8'h00, 8'h00));
    i2c_start();
    write_byte(8'h43, 8'h00, 8'h00, ack); check8("post_rst_ack", {7'd0, ack}, 8'd0);
    read_byte(1'b1, d); check8("post_rst_byte", d, 8'hFF);
    i2c_stop();

    wait_clks(10);
    check8("queue_drained", exp_q.size() == 0 ? 8'd0 : 8'd1, 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
